acc_access_ctrl: RTL and testbench

Two-port arbiter and sequencer in front of the 16-bit accumulator register. It accepts WRITE, READ and SHIFT requests from two requesters: port 0 is the ALU writeback, port 1 is the control/shift unit. It serializes the requests and drives the accumulator strobes (write enable, read enable, shift) with the required cycle sequencing. It returns read data and completion pulses to the requesters.

---
 rtl/acc_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_acc_access_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/acc_access_ctrl.sv
// Two-port arbiter/sequencer that serialises WRITE, READ and SHIFT requests onto the accumulator.
// Optional per-port completion counters are enabled by defining ACC_CTRL_OP_COUNT_EN.
module acc_access_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              acc_ctrl_clk,
  input  logic              acc_ctrl_rst_n,
  input  logic              p0_req,
  input  logic [1:0]        p0_op,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic [1:0]        p1_op,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] ctl_rdata,
  output logic              ctl_err,
  output logic              acc_wr_en,
  output logic              acc_rd_en,
  output logic              acc_shift,
  output logic [DATA_W-1:0] acc_wdata,
  input  logic [DATA_W-1:0] acc_rdata
`ifdef ACC_CTRL_OP_COUNT_EN
  ,
  output logic [15:0]       p0_op_cnt,
  output logic [15:0]       p1_op_cnt
`endif
);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpShift = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  // Each state names the strobes it registers for the following cycle, so the state register
  // runs one cycle ahead of the registered outputs.
  typedef enum logic [2:0] {
    StIdle, StWr, StRdIssue, StRdWait, StShLoad, StShApply, StResp
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              port_q, port_d;
  logic              ptr_q, ptr_d;

  logic              req_any, win;
  logic [1:0]        win_op;
  logic [DATA_W-1:0] win_data;

  logic              p0_gnt_d, p1_gnt_d, p0_done_d, p1_done_d, err_d;
  logic              wr_en_d, rd_en_d, shift_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;

  // ptr_q is the port that wins a tie; it only moves on a grant.
  always_comb begin
    req_any  = p0_req | p1_req;
    win      = (p0_req & p1_req) ? (RR_EN ? ptr_q : 1'b0) : p1_req;
    win_op   = win ? p1_op : p0_op;
    win_data = win ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge acc_ctrl_clk or negedge acc_ctrl_rst_n) begin
    if (!acc_ctrl_rst_n) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      data_q  <= '0;
      port_q  <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      port_q  <= port_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    port_d  = port_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          op_d   = win_op;
          data_d = win_data;
          port_d = win;
          ptr_d  = ~win;
          unique case (win_op)
            OpWrite: state_d = StWr;
            OpRead:  state_d = StRdIssue;
            OpShift: state_d = StShLoad;
            OpRsvd:  state_d = StResp;
            default: state_d = StIdle;
          endcase
        end
      end
      StWr:      state_d = StIdle;
      StRdIssue: state_d = StRdWait;
      StRdWait:  state_d = StResp;
      StShLoad:  state_d = StShApply;
      StShApply: state_d = StIdle;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    p0_gnt_d  = (state_q == StIdle) & req_any & ~win;
    p1_gnt_d  = (state_q == StIdle) & req_any & win;
    wr_en_d   = (state_q == StWr) | (state_q == StShLoad) | (state_q == StShApply);
    rd_en_d   = (state_q == StRdIssue);
    shift_d   = (state_q == StShLoad) | (state_q == StShApply);
    wdata_d   = '0;
    if (state_q == StWr) begin
      wdata_d = data_q;
    end else if (shift_d) begin
      wdata_d = DATA_W'(data_q[4:0]);
    end
    p0_done_d = ((state_q == StWr) | (state_q == StShApply) | (state_q == StResp)) & ~port_q;
    p1_done_d = ((state_q == StWr) | (state_q == StShApply) | (state_q == StResp)) & port_q;
    err_d     = (state_q == StResp) & (op_q == OpRsvd);
    rdata_d   = ((state_q == StResp) && (op_q == OpRead)) ? acc_rdata : ctl_rdata;
  end

  always_ff @(posedge acc_ctrl_clk or negedge acc_ctrl_rst_n) begin
    if (!acc_ctrl_rst_n) begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      ctl_err   <= 1'b0;
      ctl_rdata <= '0;
      acc_wr_en <= 1'b0;
      acc_rd_en <= 1'b0;
      acc_shift <= 1'b0;
      acc_wdata <= '0;
    end else begin
      p0_gnt    <= p0_gnt_d;
      p1_gnt    <= p1_gnt_d;
      p0_done   <= p0_done_d;
      p1_done   <= p1_done_d;
      ctl_err   <= err_d;
      ctl_rdata <= rdata_d;
      acc_wr_en <= wr_en_d;
      acc_rd_en <= rd_en_d;
      acc_shift <= shift_d;
      acc_wdata <= wdata_d;
    end
  end

`ifdef ACC_CTRL_OP_COUNT_EN
  always_ff @(posedge acc_ctrl_clk or negedge acc_ctrl_rst_n) begin
    if (!acc_ctrl_rst_n) begin
      p0_op_cnt <= 16'h0000;
      p1_op_cnt <= 16'h0000;
    end else begin
      p0_op_cnt <= p0_op_cnt + 16'(p0_done);
      p1_op_cnt <= p1_op_cnt + 16'(p1_done);
    end
  end
`endif

endmodule

// File: tb/tb_acc_access_ctrl.sv
// Directed bench for acc_access_ctrl: round-robin instance fully checked, fixed-priority
// instance checked under contention. Counter checks apply when ACC_CTRL_OP_COUNT_EN is defined.
module tb_acc_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req, p1_req;
  logic [1:0]  p0_op, p1_op;
  logic [15:0] p0_wdata, p1_wdata, acc_rdata;

  logic        p0_gnt, p1_gnt, p0_done, p1_done, ctl_err;
  logic        acc_wr_en, acc_rd_en, acc_shift;
  logic [15:0] ctl_rdata, acc_wdata;

  logic        f_p0_gnt, f_p1_gnt, f_p0_done, f_p1_done, f_ctl_err;
  logic        f_acc_wr_en, f_acc_rd_en, f_acc_shift;
  logic [15:0] f_ctl_rdata, f_acc_wdata;

`ifdef ACC_CTRL_OP_COUNT_EN
  logic [15:0] p0_op_cnt, p1_op_cnt, f_p0_op_cnt, f_p1_op_cnt;
`endif

  logic [2:0] strb, f_strb;
  logic [4:0] hs, f_hs;
  assign strb   = {acc_wr_en, acc_rd_en, acc_shift};
  assign hs     = {p0_gnt, p1_gnt, p0_done, p1_done, ctl_err};
  assign f_strb = {f_acc_wr_en, f_acc_rd_en, f_acc_shift};
  assign f_hs   = {f_p0_gnt, f_p1_gnt, f_p0_done, f_p1_done, f_ctl_err};

  always #5 clk = ~clk;

  acc_access_ctrl #(.DATA_W(16), .RR_EN(1'b1)) dut (
    .acc_ctrl_clk(clk), .acc_ctrl_rst_n(rst_n),
    .p0_req(p0_req), .p0_op(p0_op), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p1_req(p1_req), .p1_op(p1_op), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .ctl_rdata(ctl_rdata), .ctl_err(ctl_err),
    .acc_wr_en(acc_wr_en), .acc_rd_en(acc_rd_en), .acc_shift(acc_shift),
    .acc_wdata(acc_wdata), .acc_rdata(acc_rdata)
`ifdef ACC_CTRL_OP_COUNT_EN
    , .p0_op_cnt(p0_op_cnt), .p1_op_cnt(p1_op_cnt)
`endif
  );

  acc_access_ctrl #(.DATA_W(16), .RR_EN(1'b0)) dut_fp (
    .acc_ctrl_clk(clk), .acc_ctrl_rst_n(rst_n),
    .p0_req(p0_req), .p0_op(p0_op), .p0_wdata(p0_wdata), .p0_gnt(f_p0_gnt),
    .p0_done(f_p0_done),
    .p1_req(p1_req), .p1_op(p1_op), .p1_wdata(p1_wdata), .p1_gnt(f_p1_gnt),
    .p1_done(f_p1_done),
    .ctl_rdata(f_ctl_rdata), .ctl_err(f_ctl_err),
    .acc_wr_en(f_acc_wr_en), .acc_rd_en(f_acc_rd_en), .acc_shift(f_acc_shift),
    .acc_wdata(f_acc_wdata), .acc_rdata(acc_rdata)
`ifdef ACC_CTRL_OP_COUNT_EN
    , .p0_op_cnt(f_p0_op_cnt), .p1_op_cnt(f_p1_op_cnt)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    p0_req = 1'b0; p0_op = 2'b00; p0_wdata = 16'h0000;
    p1_req = 1'b0; p1_op = 2'b00; p1_wdata = 16'h0000;
    acc_rdata = 16'h1111;
    repeat (2) cyc();
    check("rst_strb", 32'(strb), 32'h0);
    check("rst_hs", 32'(hs), 32'h0);
    check("rst_wdata", 32'(acc_wdata), 32'h0);
    check("rst_rdata", 32'(ctl_rdata), 32'h0);
    rst_n = 1'b1;
    cyc();

    // p0 WRITE
    p0_req = 1'b1; p0_op = 2'b00; p0_wdata = 16'h1234;
    cyc(); check("wr_gnt", 32'(hs), 32'b10000); p0_req = 1'b0;
    cyc(); check("wr_strb", 32'(strb), 32'b100);
    check("wr_data", 32'(acc_wdata), 32'h1234);
    check("wr_done", 32'(hs), 32'b00100);
    cyc(); check("wr_after_strb", 32'(strb), 32'h0);
    check("wr_after_hs", 32'(hs), 32'h0);

    // p1 READ, data only valid during G+2
    p1_req = 1'b1; p1_op = 2'b01; p1_wdata = 16'h0000;
    cyc(); check("rd_gnt", 32'(hs), 32'b01000); p1_req = 1'b0;
    cyc(); check("rd_issue_strb", 32'(strb), 32'b010);
    check("rd_issue_hs", 32'(hs), 32'h0);
    cyc(); check("rd_wait_strb", 32'(strb), 32'h0);
    check("rd_wait_hs", 32'(hs), 32'h0);
    acc_rdata = 16'hBEEF;
    cyc(); check("rd_done", 32'(hs), 32'b00010);
    check("rd_data", 32'(ctl_rdata), 32'hBEEF);
    check("rd_resp_strb", 32'(strb), 32'h0);
    acc_rdata = 16'h2222;
    cyc(); check("rd_hold", 32'(ctl_rdata), 32'hBEEF);
    check("rd_after_hs", 32'(hs), 32'h0);

    // p0 SHIFT, upper bits of wdata must be masked
    p0_req = 1'b1; p0_op = 2'b10; p0_wdata = 16'hFFF5;
    cyc(); check("sh_gnt", 32'(hs), 32'b10000); p0_req = 1'b0;
    cyc(); check("sh_load_strb", 32'(strb), 32'b101);
    check("sh_load_data", 32'(acc_wdata), 32'h0015);
    check("sh_load_hs", 32'(hs), 32'h0);
    cyc(); check("sh_apply_strb", 32'(strb), 32'b101);
    check("sh_apply_data", 32'(acc_wdata), 32'h0015);
    check("sh_done", 32'(hs), 32'b00100);
    cyc(); check("sh_after_strb", 32'(strb), 32'h0);
    check("sh_after_hs", 32'(hs), 32'h0);

    // p1 reserved opcode
    p1_req = 1'b1; p1_op = 2'b11; p1_wdata = 16'h00FF;
    cyc(); check("rsv_gnt", 32'(hs), 32'b01000); p1_req = 1'b0;
    cyc(); check("rsv_done_err", 32'(hs), 32'b00011);
    check("rsv_strb", 32'(strb), 32'h0);
    check("rsv_rdata_kept", 32'(ctl_rdata), 32'hBEEF);
    cyc(); check("rsv_after_hs", 32'(hs), 32'h0);

    // Reset while a read is in flight
    p1_req = 1'b1; p1_op = 2'b01;
    cyc(); check("rrst_gnt", 32'(hs), 32'b01000); p1_req = 1'b0;
    cyc(); check("rrst_issue", 32'(strb), 32'b010);
    #1 rst_n = 1'b0;
    #1 check("rrst_async_strb", 32'(strb), 32'h0);
    check("rrst_async_hs", 32'(hs), 32'h0);
    check("rrst_async_rdata", 32'(ctl_rdata), 32'h0);
    cyc(); cyc(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); check("rrst_no_done", 32'(hs), 32'h0);
    end

    // Continuous contention: round-robin alternates, fixed priority starves port 1
    p0_req = 1'b1; p0_op = 2'b00; p0_wdata = 16'h00A0;
    p1_req = 1'b1; p1_op = 2'b00; p1_wdata = 16'h00B1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      cyc();
      check("rr_gnt", 32'({p0_gnt, p1_gnt}), 32'(exp_g));
      check("fp_gnt", 32'({f_p0_gnt, f_p1_gnt}), 32'b10);
      cyc();
      check("rr_done", 32'({p0_done, p1_done}), 32'(exp_g));
      check("rr_data", 32'(acc_wdata), (k % 2 == 0) ? 32'h00A0 : 32'h00B1);
      check("fp_done", 32'(f_hs), 32'b00100);
      check("fp_strb", 32'(f_strb), 32'b100);
      check("fp_data", 32'(f_acc_wdata), 32'h00A0);
      if (k == 3) begin
        p0_req = 1'b0; p1_req = 1'b0;
      end
    end
    cyc(); check("rr_quiet", 32'(hs), 32'h0);
    check("fp_quiet", 32'(f_hs), 32'h0);

    // One more p0 op (reserved) so port 0 totals three completions since reset
    p0_req = 1'b1; p0_op = 2'b11;
    cyc(); check("rsv0_gnt", 32'(hs), 32'b10000); p0_req = 1'b0;
    cyc(); check("rsv0_done", 32'(hs), 32'b00101);
    cyc();
    check("rdata_cleared", 32'(ctl_rdata), 32'h0);
    check("fp_rdata_cleared", 32'(f_ctl_rdata), 32'h0);
`ifdef ACC_CTRL_OP_COUNT_EN
    check("p0_cnt", 32'(p0_op_cnt), 32'd3);
    check("p1_cnt", 32'(p1_op_cnt), 32'd2);
    check("fp_p0_cnt", 32'(f_p0_op_cnt), 32'd5);
    check("fp_p1_cnt", 32'(f_p1_op_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
